// File: rtl/regfile_sb_pkg.sv
// Shared constants and writeback-port priority helper for the regfile_sb slice.
package regfile_sb_pkg;

    localparam int unsigned DefXlen  = 32;
    localparam int unsigned DefNregs = 32;

    // Upper bound on writeback ports handled by wb_pick.
    localparam int unsigned MaxWb   = 8;
    localparam int unsigned WbIdxW  = 3;

    typedef struct packed {
        logic              hit;
        logic [WbIdxW-1:0] idx;
    } wb_pick_t;

    // Highest-index matching port wins, mirroring the array write ordering.
    function automatic wb_pick_t wb_pick(input logic [MaxWb-1:0] match);
        wb_pick_t res;
        res = '0;
        for (int j = 0; j < MaxWb; j++) begin
            if (match[j]) begin
                res.hit = 1'b1;
                res.idx = WbIdxW'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-side bus of regfile_sb: read ports, issue handshake, writeback ports, flush.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN  = DefXlen,
    parameter int unsigned NREGS = DefNregs,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWB   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                issue_valid;
    logic [NRD-1:0]      issue_src_en;
    logic                issue_wr;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic [NWB-1:0]      wb_valid;
    logic [NWB*AW-1:0]   wb_rd;
    logic [NWB*XLEN-1:0] wb_data;
    logic                flush;
    logic [AW:0]         pend_cnt;

    modport master (
        output rd_addr, issue_valid, issue_src_en, issue_wr, issue_rd,
        output wb_valid, wb_rd, wb_data, flush,
        input  rd_data, rd_busy, issue_ready, pend_cnt
    );

    modport slave (
        input  rd_addr, issue_valid, issue_src_en, issue_wr, issue_rd,
        input  wb_valid, wb_rd, wb_data, flush,
        output rd_data, rd_busy, issue_ready, pend_cnt
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: per-register pending bits, hazard detection, pending count.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned NREGS    = DefNregs,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREGS-1:0]  wb_hit,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              issue_valid,
    input  logic [NRD-1:0]    issue_src_en,
    input  logic              issue_wr,
    input  logic [AW-1:0]     issue_rd,
    input  logic              flush,
    output logic [NRD-1:0]    rd_busy,
    output logic              issue_ready,
    output logic [AW:0]       pend_cnt
);

    logic [NREGS-1:0] pend_q, pend_d, pend_eff;
    logic [AW:0]      cnt_d;
    logic             set_ok;
    logic             issue_set;

    // A writeback in flight satisfies the pending write this same cycle.
    assign pend_eff = pend_q & ~wb_hit;

    assign set_ok    = !((ZERO_REG != 0) && (issue_rd == '0));
    assign issue_set = issue_valid & issue_ready & issue_wr & set_ok;

    // Busy per read port and RAW/WAW hazard check; issue_valid deliberately unused here.
    always_comb begin
        issue_ready = 1'b1;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = pend_eff[rd_addr[i*AW +: AW]];
            if (issue_src_en[i] && rd_busy[i]) issue_ready = 1'b0;
        end
        if (issue_wr && pend_eff[issue_rd]) issue_ready = 1'b0;
    end

    // Next pending state: issue set beats wb clear, flush beats everything.
    always_comb begin
        pend_d = pend_eff;
        if (issue_set) pend_d[issue_rd] = 1'b1;
        if (flush) pend_d = '0;
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, pend_d[r]};
        end
    end

    // Pending bits and their population count update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            pend_cnt <= '0;
        end else begin
            pend_q   <= pend_d;
            pend_cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass, hardwired x0 and pending scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN     = DefXlen,
    parameter int unsigned NREGS    = DefNregs,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWB      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [NREGS-1:0]    wb_hit;
    logic [NRD*XLEN-1:0] rd_data;
    logic [MaxWb-1:0]    rd_match [NRD];
    wb_pick_t            rd_pick  [NRD];

    // Register array; later ports overwrite earlier ones on a same-register collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            for (int j = 0; j < NWB; j++) begin
                if (bus.wb_valid[j] &&
                    !((ZERO_REG != 0) && (bus.wb_rd[j*AW +: AW] == '0))) begin
                    regs_q[bus.wb_rd[j*AW +: AW]] <= bus.wb_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Which registers are targeted by any valid writeback this cycle.
    always_comb begin
        wb_hit = '0;
        for (int j = 0; j < NWB; j++) begin
            if (bus.wb_valid[j]) wb_hit[bus.wb_rd[j*AW +: AW]] = 1'b1;
        end
    end

    // Read ports: x0 forced to zero, then bypass from winning wb port, else the array.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_match[i] = '0;
            for (int j = 0; j < NWB; j++) begin
                rd_match[i][j] = bus.wb_valid[j] &&
                                 (bus.wb_rd[j*AW +: AW] == bus.rd_addr[i*AW +: AW]);
            end
            rd_pick[i] = wb_pick(rd_match[i]);
            if ((ZERO_REG != 0) && (bus.rd_addr[i*AW +: AW] == '0)) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end else if (rd_pick[i].hit) begin
                rd_data[i*XLEN +: XLEN] = bus.wb_data[int'(rd_pick[i].idx)*XLEN +: XLEN];
            end else begin
                rd_data[i*XLEN +: XLEN] = regs_q[bus.rd_addr[i*AW +: AW]];
            end
        end
    end

    assign bus.rd_data = rd_data;

    regfile_sb_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .wb_hit       (wb_hit),
        .rd_addr      (bus.rd_addr),
        .issue_valid  (bus.issue_valid),
        .issue_src_en (bus.issue_src_en),
        .issue_wr     (bus.issue_wr),
        .issue_rd     (bus.issue_rd),
        .flush        (bus.flush),
        .rd_busy      (bus.rd_busy),
        .issue_ready  (bus.issue_ready),
        .pend_cnt     (bus.pend_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb with a behavioural register/pending model.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWB(2)) bus ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWB(2), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Stimulus variables
    logic [4:0]  ra [2];
    logic        se [2];
    logic        wv [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic        iv, iw, fl;
    logic [4:0]  ird;

    // Reference model state
    logic [31:0] m_reg  [32];
    bit          m_pend [32];

    task automatic clear_in();
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0; se[i] = 1'b0; wv[i] = 1'b0; wa[i] = '0; wd[i] = '0;
        end
        iv = 1'b0; iw = 1'b0; fl = 1'b0; ird = '0;
    endtask

    task automatic apply();
        bus.rd_addr      = {ra[1], ra[0]};
        bus.issue_src_en = {se[1], se[0]};
        bus.wb_valid     = {wv[1], wv[0]};
        bus.wb_rd        = {wa[1], wa[0]};
        bus.wb_data      = {wd[1], wd[0]};
        bus.issue_valid  = iv;
        bus.issue_wr     = iw;
        bus.issue_rd     = ird;
        bus.flush        = fl;
    endtask

    function automatic bit wb_targets(input logic [4:0] r);
        return (wv[0] && wa[0] == r) || (wv[1] && wa[1] == r);
    endfunction

    function automatic bit e_busy(input logic [4:0] r);
        return m_pend[r] && !wb_targets(r);
    endfunction

    function automatic logic [31:0] e_data(input logic [4:0] a);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = m_reg[a];
        for (int j = 0; j < 2; j++) if (wv[j] && wa[j] == a) v = wd[j];
        return v;
    endfunction

    function automatic bit e_ready();
        for (int i = 0; i < 2; i++) if (se[i] && e_busy(ra[i])) return 1'b0;
        if (iw && e_busy(ird)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int e_cnt();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_commit();
        bit np [32];
        bit fire;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin m_reg[r] = '0; m_pend[r] = 1'b0; end
            return;
        end
        fire = iv && e_ready() && iw && ird != 0;
        for (int r = 0; r < 32; r++) np[r] = e_busy(5'(r));
        if (fire) np[ird] = 1'b1;
        if (fl) for (int r = 0; r < 32; r++) np[r] = 1'b0;
        for (int j = 0; j < 2; j++) if (wv[j] && wa[j] != 0) m_reg[wa[j]] = wd[j];
        m_pend = np;
    endfunction

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_in(); rst = 1'b1; apply(); tick(); rst = 1'b0;
        ra[0] = 5'd5; ra[1] = 5'd0; apply(); #1;
        total++; if (bus.rd_data[31:0] !== 32'h0) begin bad++;
            $display("FAIL reset_rd0 got=%h exp=0", bus.rd_data[31:0]); end
        total++; if (bus.rd_data[63:32] !== 32'h0) begin bad++;
            $display("FAIL reset_rd1 got=%h exp=0", bus.rd_data[63:32]); end
        total++; if (bus.rd_busy !== 2'b00) begin bad++;
            $display("FAIL reset_busy got=%b exp=00", bus.rd_busy); end
        total++; if (bus.issue_ready !== 1'b1) begin bad++;
            $display("FAIL reset_ready got=%b exp=1", bus.issue_ready); end
        total++; if (bus.pend_cnt !== 6'd0) begin bad++;
            $display("FAIL reset_cnt got=%0d exp=0", bus.pend_cnt); end
    endtask

    task automatic test_raw();
        clear_in(); iv = 1'b1; iw = 1'b1; ird = 5'd7; apply(); #1;
        total++; if (bus.issue_ready !== 1'b1) begin bad++;
            $display("FAIL raw_first_ready got=%b exp=1", bus.issue_ready); end
        tick();
        total++; if (bus.pend_cnt !== 6'd1) begin bad++;
            $display("FAIL raw_cnt_set got=%0d exp=1", bus.pend_cnt); end
        clear_in(); iv = 1'b1; se[0] = 1'b1; ra[0] = 5'd7; apply(); #1;
        total++; if (bus.issue_ready !== 1'b0) begin bad++;
            $display("FAIL raw_hazard_ready got=%b exp=0", bus.issue_ready); end
        total++; if (bus.rd_busy[0] !== 1'b1) begin bad++;
            $display("FAIL raw_busy got=%b exp=1", bus.rd_busy[0]); end
        tick();
        wv[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'hDEAD_BEEF; apply(); #1;
        total++; if (bus.rd_data[31:0] !== 32'hDEAD_BEEF) begin bad++;
            $display("FAIL raw_bypass got=%h exp=deadbeef", bus.rd_data[31:0]); end
        total++; if (bus.issue_ready !== 1'b1) begin bad++;
            $display("FAIL raw_wb_ready got=%b exp=1", bus.issue_ready); end
        total++; if (bus.pend_cnt !== 6'd1) begin bad++;
            $display("FAIL raw_cnt_before got=%0d exp=1", bus.pend_cnt); end
        tick();
        total++; if (bus.pend_cnt !== 6'd0) begin bad++;
            $display("FAIL raw_cnt_after got=%0d exp=0", bus.pend_cnt); end
        clear_in(); ra[0] = 5'd7; apply(); #1;
        total++; if (bus.rd_data[31:0] !== 32'hDEAD_BEEF) begin bad++;
            $display("FAIL raw_array got=%h exp=deadbeef", bus.rd_data[31:0]); end
    endtask

    task automatic test_wb_priority();
        clear_in(); wv[0] = 1'b1; wv[1] = 1'b1; wa[0] = 5'd3; wa[1] = 5'd3;
        wd[0] = 32'h11; wd[1] = 32'h22; ra[0] = 5'd3; apply(); #1;
        total++; if (bus.rd_data[31:0] !== 32'h22) begin bad++;
            $display("FAIL prio_bypass got=%h exp=22", bus.rd_data[31:0]); end
        tick();
        clear_in(); ra[0] = 5'd3; apply(); #1;
        total++; if (bus.rd_data[31:0] !== 32'h22) begin bad++;
            $display("FAIL prio_array got=%h exp=22", bus.rd_data[31:0]); end
        wv[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF; ra[1] = 5'd0; apply(); #1;
        total++; if (bus.rd_data[63:32] !== 32'h0) begin bad++;
            $display("FAIL x0_bypass got=%h exp=0", bus.rd_data[63:32]); end
        tick();
        clear_in(); ra[1] = 5'd0; apply(); #1;
        total++; if (bus.rd_data[63:32] !== 32'h0) begin bad++;
            $display("FAIL x0_array got=%h exp=0", bus.rd_data[63:32]); end
    endtask

    task automatic test_set_beats_clear();
        clear_in(); iv = 1'b1; iw = 1'b1; ird = 5'd9; apply(); tick();
        wv[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h9; apply(); #1;
        total++; if (bus.issue_ready !== 1'b1) begin bad++;
            $display("FAIL setclr_ready got=%b exp=1", bus.issue_ready); end
        tick();
        clear_in(); ra[0] = 5'd9; apply(); #1;
        total++; if (bus.pend_cnt !== 6'd1) begin bad++;
            $display("FAIL setclr_cnt got=%0d exp=1", bus.pend_cnt); end
        total++; if (bus.rd_busy[0] !== 1'b1) begin bad++;
            $display("FAIL setclr_busy got=%b exp=1", bus.rd_busy[0]); end
        wv[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h90; apply(); tick();
    endtask

    task automatic test_flush();
        for (int r = 4; r <= 6; r++) begin
            clear_in(); iv = 1'b1; iw = 1'b1; ird = 5'(r); apply(); tick();
        end
        total++; if (bus.pend_cnt !== 6'd3) begin bad++;
            $display("FAIL flush_cnt3 got=%0d exp=3", bus.pend_cnt); end
        clear_in(); fl = 1'b1; iv = 1'b1; iw = 1'b1; ird = 5'd8; apply(); tick();
        clear_in(); ra[0] = 5'd5; ra[1] = 5'd8; apply(); #1;
        total++; if (bus.pend_cnt !== 6'd0) begin bad++;
            $display("FAIL flush_cnt0 got=%0d exp=0", bus.pend_cnt); end
        total++; if (bus.rd_busy !== 2'b00) begin bad++;
            $display("FAIL flush_busy got=%b exp=00", bus.rd_busy); end
        wv[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'h55; apply(); tick();
        clear_in(); ra[0] = 5'd5; apply(); #1;
        total++; if (bus.rd_data[31:0] !== 32'h55) begin bad++;
            $display("FAIL flush_wb_data got=%h exp=55", bus.rd_data[31:0]); end
        total++; if (bus.pend_cnt !== 6'd0) begin bad++;
            $display("FAIL flush_wb_cnt got=%0d exp=0", bus.pend_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_in(); iv = 1'b1; iw = 1'b1; ird = 5'd2; apply(); tick();
        clear_in(); rst = 1'b1; wv[0] = 1'b1; wa[0] = 5'd2; wd[0] = 32'h99; apply(); tick();
        rst = 1'b0; clear_in(); ra[0] = 5'd2; apply(); #1;
        total++; if (bus.rd_data[31:0] !== 32'h0) begin bad++;
            $display("FAIL rstmid_data got=%h exp=0", bus.rd_data[31:0]); end
        total++; if (bus.rd_busy[0] !== 1'b0) begin bad++;
            $display("FAIL rstmid_busy got=%b exp=0", bus.rd_busy[0]); end
        total++; if (bus.pend_cnt !== 6'd0) begin bad++;
            $display("FAIL rstmid_cnt got=%0d exp=0", bus.pend_cnt); end
        wv[0] = 1'b1; wa[0] = 5'd2; wd[0] = 32'h77; apply(); tick();
        clear_in(); ra[0] = 5'd2; apply(); #1;
        total++; if (bus.rd_data[31:0] !== 32'h77 || bus.pend_cnt !== 6'd0) begin bad++;
            $display("FAIL rstmid_wb got=%h/%0d exp=77/0", bus.rd_data[31:0], bus.pend_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                ra[i] = 5'($urandom_range(0, 7));
                se[i] = 1'($urandom);
                wv[i] = ($urandom_range(0, 9) < 4);
                wa[i] = 5'($urandom_range(0, 7));
                wd[i] = $urandom;
            end
            iv  = 1'($urandom);
            iw  = 1'($urandom);
            ird = 5'($urandom_range(0, 7));
            fl  = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 63) == 0);
            apply(); #1;
            for (int i = 0; i < 2; i++) begin
                total++; if (bus.rd_data[i*32 +: 32] !== e_data(ra[i])) begin bad++;
                    $display("FAIL rand_data%0d cyc=%0d got=%h exp=%h", i, n,
                             bus.rd_data[i*32 +: 32], e_data(ra[i])); end
                total++; if (bus.rd_busy[i] !== e_busy(ra[i])) begin bad++;
                    $display("FAIL rand_busy%0d cyc=%0d got=%b exp=%b", i, n,
                             bus.rd_busy[i], e_busy(ra[i])); end
            end
            total++; if (bus.issue_ready !== e_ready()) begin bad++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", n, bus.issue_ready, e_ready()); end
            tick();
            total++; if (int'(bus.pend_cnt) != e_cnt()) begin bad++;
                $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", n, bus.pend_cnt, e_cnt()); end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin m_reg[r] = '0; m_pend[r] = 1'b0; end
        clear_in(); apply();
        test_reset();
        test_raw();
        test_wb_priority();
        test_set_beats_clear();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
